// File: rtl/display_scheduler.sv
// Page sequencer and edit-blink controller feeding the 8-digit seven-segment scan driver.
// Optional: define HOUR_LZ_BLANK_EN to blank a zero hour-tens digit on the time page.
module display_scheduler #(
   parameter int unsigned TIME_DWELL = 8000,
   parameter int unsigned DATE_DWELL = 2000,
   parameter int unsigned BLINK_HALF = 250
) (
   input  logic        clk_1khz,
   input  logic        rst,
   input  logic [7:0]  hour,
   input  logic [7:0]  min,
   input  logic [7:0]  sec,
   input  logic [15:0] year,
   input  logic [7:0]  month,
   input  logic [7:0]  day,
   input  logic        mode_btn,
   input  logic        edit_en,
   input  logic [2:0]  edit_sel,
   output logic [3:0]  num1,
   output logic [3:0]  num2,
   output logic [3:0]  num3,
   output logic [3:0]  num4,
   output logic [3:0]  num5,
   output logic [3:0]  num6,
   output logic [3:0]  num7,
   output logic [3:0]  num8,
   output logic [7:0]  digit_blank,
   output logic        page_date,
   output logic [1:0]  mode
);

   localparam int unsigned DWELL_W = 16;
   localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [7:0]  SEP_MASK = 8'b0010_0100;

   typedef enum logic [1:0] {
      MODE_AUTO     = 2'd0,
      MODE_FIX_TIME = 2'd1,
      MODE_FIX_DATE = 2'd2,
      MODE_BAD      = 2'd3
   } mode_t;

   mode_t               r_mode,   w_mode_nxt;
   logic                r_page,   w_page_nxt;
   logic [DWELL_W-1:0]  r_dwell,  w_dwell_nxt;
   logic [BLINK_W-1:0]  r_blink,  w_blink_nxt;
   logic                r_hidden, w_hidden_nxt;
   logic                r_edit_en_d;
   logic [2:0]          r_edit_sel_d;
   logic [31:0]         r_digits, w_digits_nxt;
   logic [7:0]          r_blank,  w_blank_nxt;

   // State and output registers
   always_ff @(posedge clk_1khz or posedge rst) begin
      if (rst) begin
         r_mode       <= MODE_AUTO;
         r_page       <= 1'b0;
         r_dwell      <= '0;
         r_blink      <= '0;
         r_hidden     <= 1'b0;
         r_edit_en_d  <= 1'b0;
         r_edit_sel_d <= 3'd0;
         r_digits     <= 32'd0;
         r_blank      <= 8'h00;
      end else begin
         r_mode       <= w_mode_nxt;
         r_page       <= w_page_nxt;
         r_dwell      <= w_dwell_nxt;
         r_blink      <= w_blink_nxt;
         r_hidden     <= w_hidden_nxt;
         r_edit_en_d  <= edit_en;
         r_edit_sel_d <= edit_sel;
         r_digits     <= w_digits_nxt;
         r_blank      <= w_blank_nxt;
      end
   end

   // Next-state: mode, page rotation, blink, digit mapping
   always_comb begin
      w_mode_nxt   = r_mode;
      w_page_nxt   = r_page;
      w_dwell_nxt  = r_dwell;
      w_blink_nxt  = r_blink;
      w_hidden_nxt = r_hidden;
      w_digits_nxt = 32'd0;
      w_blank_nxt  = 8'h00;

      // A mode press overrides a coincident dwell expiry
      if (mode_btn || (r_mode == MODE_BAD)) begin
         w_dwell_nxt = '0;
         case (r_mode)
            MODE_AUTO: begin
               w_mode_nxt = mode_btn ? MODE_FIX_TIME : MODE_AUTO;
               w_page_nxt = 1'b0;
            end
            MODE_FIX_TIME: begin
               w_mode_nxt = MODE_FIX_DATE;
               w_page_nxt = 1'b1;
            end
            default: begin
               w_mode_nxt = MODE_AUTO;
               w_page_nxt = 1'b0;
            end
         endcase
      end else if ((r_mode == MODE_AUTO) && !edit_en) begin
         if (!r_page && (r_dwell == DWELL_W'(TIME_DWELL - 1))) begin
            w_page_nxt  = 1'b1;
            w_dwell_nxt = '0;
         end else if (r_page && (r_dwell == DWELL_W'(DATE_DWELL - 1))) begin
            w_page_nxt  = 1'b0;
            w_dwell_nxt = '0;
         end else begin
            w_dwell_nxt = r_dwell + DWELL_W'(1);
         end
      end

      // Blink restarts visible on a new edit session or a new digit selection
      if (!edit_en || !r_edit_en_d || (edit_sel != r_edit_sel_d)) begin
         w_blink_nxt  = '0;
         w_hidden_nxt = 1'b0;
      end else if (r_blink == BLINK_W'(BLINK_HALF - 1)) begin
         w_blink_nxt  = '0;
         w_hidden_nxt = ~r_hidden;
      end else begin
         w_blink_nxt  = r_blink + BLINK_W'(1);
      end

      if (w_page_nxt) begin
         w_digits_nxt = {year, month, day};
      end else begin
         w_digits_nxt = {hour, 4'd0, min, 4'd0, sec};
         w_blank_nxt  = SEP_MASK;
      end

`ifdef HOUR_LZ_BLANK_EN
      if (!w_page_nxt && (hour[7:4] == 4'd0) && !(edit_en && (edit_sel == 3'd0))) begin
         w_blank_nxt[0] = 1'b1;
      end
`else
`endif

      if (w_hidden_nxt) begin
         w_blank_nxt = w_blank_nxt | (8'(1) << edit_sel);
      end
   end

   assign num1        = r_digits[31:28];
   assign num2        = r_digits[27:24];
   assign num3        = r_digits[23:20];
   assign num4        = r_digits[19:16];
   assign num5        = r_digits[15:12];
   assign num6        = r_digits[11:8];
   assign num7        = r_digits[7:4];
   assign num8        = r_digits[3:0];
   assign digit_blank = r_blank;
   assign page_date   = r_page;
   assign mode        = r_mode;

endmodule
